// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator (pwm_multi_ch).
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned CH_NUM_MAX = 16;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: double-buffered compare value and registered comparator.
// With PWM_POLARITY_EN defined, an output polarity bit is buffered alongside ccr.
module pwm_cmp_ch
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk_50mhz,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_wr,
  input  logic             load_act,
  input  logic [CNT_W-1:0] ccr_in,
  input  logic [CNT_W-1:0] cnt,
`ifdef PWM_POLARITY_EN
  input  logic             pol_in,
`endif
  output logic             pwm
);

  logic [CNT_W-1:0] ccr_sh_q;
  logic [CNT_W-1:0] ccr_sh_d;
  logic [CNT_W-1:0] ccr_act_q;
  logic [CNT_W-1:0] ccr_act_d;
  logic             pwm_d;
  logic             idle_lvl;

`ifdef PWM_POLARITY_EN
  logic pol_sh_q;
  logic pol_sh_d;
  logic pol_act_q;
  logic pol_act_d;

  // Polarity follows the same shadow/active path as the compare value.
  always_comb begin
    pol_sh_d  = pol_sh_q;
    pol_act_d = pol_act_q;
    if (cfg_wr)   pol_sh_d  = pol_in;
    if (load_act) pol_act_d = pol_sh_q;
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      pol_sh_q  <= 1'b0;
      pol_act_q <= 1'b0;
    end else begin
      pol_sh_q  <= pol_sh_d;
      pol_act_q <= pol_act_d;
    end
  end

  assign idle_lvl = pol_act_q;
`else
  assign idle_lvl = 1'b0;
`endif

  // Shadow takes writes; active takes shadow when the top signals a transfer.
  always_comb begin
    ccr_sh_d  = ccr_sh_q;
    ccr_act_d = ccr_act_q;
    if (cfg_wr)   ccr_sh_d  = ccr_in;
    if (load_act) ccr_act_d = ccr_sh_q;
    pwm_d = en ? ((cnt < ccr_act_q) ^ idle_lvl) : idle_lvl;
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      ccr_sh_q  <= '0;
      ccr_act_q <= '0;
      pwm       <= 1'b0;
    end else begin
      ccr_sh_q  <= ccr_sh_d;
      ccr_act_q <= ccr_act_d;
      pwm       <= pwm_d;
    end
  end

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shared edge/center-aligned period counter with per-channel comparators.
// Optional macro PWM_POLARITY_EN adds a buffered per-channel output polarity input (pol).
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int unsigned CH_NUM = 4,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                    clk_50mhz,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    cfg_wr,
  input  logic [CNT_W-1:0]        arr_in,
  input  logic [CH_NUM*CNT_W-1:0] ccr_in,
  input  logic                    mode_in,
`ifdef PWM_POLARITY_EN
  input  logic [CH_NUM-1:0]       pol,
`endif
  output logic [CH_NUM-1:0]       pwm,
  output logic                    period_end,
  output logic                    cfg_pending
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  dir_e             dir_q;
  dir_e             dir_d;
  logic [CNT_W-1:0] arr_sh_q;
  logic [CNT_W-1:0] arr_sh_d;
  logic [CNT_W-1:0] arr_act_q;
  logic [CNT_W-1:0] arr_act_d;
  logic             mode_sh_q;
  logic             mode_sh_d;
  logic             mode_act_q;
  logic             mode_act_d;
  logic             pend_d;
  logic             upd_evt;
  logic             load_act;

  // Last cycle of the current period under the active mode.
  always_comb begin
    upd_evt = 1'b0;
    if (mode_act_q == MODE_EDGE) upd_evt = (cnt_q == arr_act_q);
    else                         upd_evt = (dir_q == DIR_DOWN) && (cnt_q == '0);
  end

  // Counter/direction sequencing and shadow-to-active transfer.
  always_comb begin
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    arr_sh_d   = arr_sh_q;
    arr_act_d  = arr_act_q;
    mode_sh_d  = mode_sh_q;
    mode_act_d = mode_act_q;
    pend_d     = cfg_pending;
    load_act   = 1'b0;

    if (cfg_wr) begin
      arr_sh_d  = arr_in;
      mode_sh_d = mode_in;
    end

    if (!en) begin
      cnt_d    = '0;
      dir_d    = DIR_UP;
      load_act = 1'b1;
      pend_d   = cfg_wr;
    end else if (upd_evt) begin
      cnt_d    = '0;
      dir_d    = DIR_UP;
      load_act = cfg_pending;
      pend_d   = cfg_wr;
    end else begin
      pend_d = cfg_pending | cfg_wr;
      if (mode_act_q == MODE_EDGE) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (dir_q == DIR_UP) begin
        // Turnaround at the top holds the count for one extra cycle.
        if (cnt_q == arr_act_q) dir_d = DIR_DOWN;
        else                    cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    if (load_act) begin
      arr_act_d  = arr_sh_q;
      mode_act_d = mode_sh_q;
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      dir_q       <= DIR_UP;
      arr_sh_q    <= '0;
      arr_act_q   <= '0;
      mode_sh_q   <= MODE_EDGE;
      mode_act_q  <= MODE_EDGE;
      cfg_pending <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      arr_sh_q    <= arr_sh_d;
      arr_act_q   <= arr_act_d;
      mode_sh_q   <= mode_sh_d;
      mode_act_q  <= mode_act_d;
      cfg_pending <= pend_d;
    end
  end

  // Reset config (arr=0, edge) is itself a standing update event, so reset masks the pulse.
  assign period_end = rst_n & en & upd_evt;

  for (genvar i = 0; i < CH_NUM_MAX; i++) begin : g_ch
    if (i < CH_NUM) begin : g_on
      pwm_cmp_ch #(
        .CNT_W(CNT_W)
      ) u_ch (
        .clk_50mhz(clk_50mhz),
        .rst_n    (rst_n),
        .en       (en),
        .cfg_wr   (cfg_wr),
        .load_act (load_act),
        .ccr_in   (ccr_in[i*CNT_W +: CNT_W]),
        .cnt      (cnt_q),
`ifdef PWM_POLARITY_EN
        .pol_in   (pol[i]),
`endif
        .pwm      (pwm[i])
      );
    end
  end

endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
Multi-channel PWM generator, the parametrised successor of the single-channel PWM block. One shared period counter drives CH_NUM independent duty comparators. Configuration is double-buffered: writes go to shadow registers and become active only at a period boundary, so there are no glitch periods. Supports edge-aligned and center-aligned modes. Used for beeper tones, LED dimming and multi-phase drive off the 50 MHz system clock.

Parameters:
CH_NUM, 4, number of PWM channels (1..16)
CNT_W, 32, counter/compare width in bits (2..32)

Ports:
clk_50mhz  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  run enable; low forces idle
cfg_wr  input  1  single-cycle strobe capturing arr_in/ccr_in/mode_in into shadow
arr_in  input  CNT_W  period reload value
ccr_in  input  CH_NUM*CNT_W  compare values, channel i at [i*CNT_W +: CNT_W]
mode_in  input  1  0 = edge-aligned, 1 = center-aligned
pwm  output  CH_NUM  registered PWM outputs
period_end  output  1  one-cycle pulse on the last cycle of each period
cfg_pending  output  1  shadow written, not yet transferred to active

Behaviour:
- Reset: cnt=0, dir=up, shadow and active arr/ccr/mode=0, pwm=0, period_end=0, cfg_pending=0.
- en=0: cnt=0, dir=up, pwm=0, period_end=0. Active registers load from shadow every cycle and cfg_pending clears, so the first period after enable uses the latest config.
- Edge mode: cnt runs 0..arr_act, then wraps to 0. Period = arr_act+1 cycles.
- Center mode: cnt counts up 0..arr_act. At arr_act, dir flips to down and cnt holds one extra cycle. It then counts down to 0; at 0, dir flips to up and cnt holds. Period = 2*(arr_act+1) cycles.
- Compare: pwm[i] <= (cnt < ccr_act[i]), registered, so there is one cycle of latency from cnt.
  - Edge mode: high time = ccr cycles.
  - Center mode: high time = 2*ccr cycles, centred on cnt=0.
- Update event: edge mode at cnt==arr_act; center mode at dir==down && cnt==0.
  - period_end is asserted in that same cycle.
  - arr_act, ccr_act[] and mode_act load from shadow when cfg_pending=1.
  - The new values take effect on the following cycle, and the counter restarts at 0 with dir=up.
- cfg_wr sets cfg_pending=1. cfg_wr in the same cycle as an update event: active takes the old shadow, shadow takes the new inputs, and cfg_pending stays 1.
- Boundaries:
  - ccr=0 gives a constant 0.
  - ccr>arr gives a constant 1 (edge mode) and a constant 1 (center mode).
  - Edge mode with arr=0: period 1, period_end stuck high.
  - Center mode with arr=0: period 2.
- Mode changes apply only at an update event, never mid-period.
- Reset asserted mid-period returns everything to reset values immediately (asynchronous).

Optional Feature:
Macro PWM_POLARITY_EN.
- Defined: adds input pol [CH_NUM], shadowed and activated with the rest of the configuration. pwm[i] is the compare result XOR pol_act[i] while en=1; while en=0, pwm[i]=pol_act[i] (idle level).
- Undefined: no pol port; outputs are active-high and idle at 0.

Decomposition:
- Package pwm_pkg: mode constants MODE_EDGE=1'b0 and MODE_CENTER=1'b1, default CNT_W, max CH_NUM.
- Sub-module pwm_cmp_ch: one per channel, generate-instantiated. It holds the shadow and active ccr, the optional pol, and the registered comparator. The top level owns the counter, direction, update logic and arr/mode shadows.

Test Plan:
- Edge mode, arr=9, ccr={0,3,5,12}, en=1 → period 10 cycles; pwm high for 0/3/5/10 cycles per period; period_end once every 10 cycles.
- Center mode, arr=4, ccr[0]=2 → period 10 cycles; pwm[0] high for 4 consecutive cycles centred on the cnt=0 hold; period_end at down/cnt=0.
- Mid-period cfg_wr changing ccr[1] from 3 to 7 (arr=9) → current period unchanged; cfg_pending high until period_end; next period high for 7 cycles.
- cfg_wr in the same cycle as period_end → following period uses the previous shadow; the new value applies one period later; cfg_pending remains 1 across.
- Drop en mid-period, then raise it after 5 cycles → pwm=0 and cnt=0 while low; restart from cnt=0 with the latest shadow config.
- Assert rst_n low mid-period in center mode → all outputs 0 immediately; after release with en=1, counting restarts from 0 in edge mode (mode reset to 0) until the next cfg_wr.
